uart_tx_fifo: RTL
=================

# uart_tx_fifo

UART transmitter with an internal byte FIFO. Serializes 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) onto a single line. Each bit lasts CLOCKS_PER_BIT clocks, which is the same bit timing the receive side uses. It sits between user logic (valid/ready byte interface) and the FPGA TX pin, and buffers bursts so the producer does not wait on each frame.

## Interface
- CLOCKS_PER_BIT, 217, clocks per serial bit (i_Clk freq / baud); legal values are ≥ 2.
- FIFO_DEPTH, 4, byte buffer depth; must be a power of two, ≥ 2.
- i_Clk  input  1  system clock; all logic on rising edge.
- i_Rst  input  1  reset, asynchronous, active-high.
- i_TX_DV  input  1  write strobe; byte accepted on any rising edge where i_TX_DV && o_TX_Ready.
- i_TX_Byte  input  8  byte to transmit; sampled with i_TX_DV.
- o_TX_Ready  output  1  FIFO not full; combinational from the FIFO count.
- o_TX_Serial  output  1  serial line, registered, idle high.
- o_TX_Active  output  1  high while a frame (start through stop bit) is on the line.
- o_TX_Done  output  1  one-cycle pulse after each frame's stop bit completes.
- o_FIFO_Count  output  clog2(FIFO_DEPTH)+1  bytes currently buffered (excludes the byte in flight).

## Operation
- Reset values: o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_FIFO_Count=0, o_TX_Ready=1, state=IDLE, clock counter=0, bit index=0.
- Reset asserted mid-frame: o_TX_Serial goes high immediately (asynchronous). The frame is aborted and the FIFO flushed.
- FIFO: circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - Write when full: ignored and the byte dropped. The count does not change.
  - Push and pop on the same edge: count unchanged, both pointers advance.
  - Bytes are transmitted strictly in acceptance order.
- Clock counter width is clog2(CLOCKS_PER_BIT). It runs 0..CLOCKS_PER_BIT-1 and resets to 0 at every bit boundary.
- State machine:
  - IDLE:
    - Serial=1, Active=0.
    - If FIFO is non-empty: pop the head into the shift register, drive Serial=0 and Active=1, go to START_BIT.
    - Otherwise stay in IDLE.
  - START_BIT:
    - Hold Serial=0.
    - At count CLOCKS_PER_BIT-1: drive Serial=shift[0], set bit index=0, go to DATA_BITS.
  - DATA_BITS:
    - At count CLOCKS_PER_BIT-1:
      - If bit index < 7: increment the bit index and drive Serial=shift[index+1].
      - If bit index = 7: drive Serial=1 and go to STOP_BIT.
  - STOP_BIT:
    - Hold Serial=1.
    - At count CLOCKS_PER_BIT-1: drive Active=0 and Done=1, go to CLEANUP.
  - CLEANUP: one cycle. Done=1, Serial=1. Next cycle Done=0, go to IDLE.
  - Unused state encodings: return to IDLE with Serial=1.
- The shift register is loaded only in IDLE. Writes during a frame affect only the FIFO.

## Timing
- E0 is the edge that accepts a byte into an empty FIFO with the transmitter in IDLE.
  - o_FIFO_Count=1 after E0.
  - The IDLE pop happens at E1. o_FIFO_Count returns to 0 and o_TX_Serial is low from E1.
- Each bit holds for exactly CLOCKS_PER_BIT cycles:
  - start bit: E1..E(CPB)
  - data bit n: E(1+(n+1)·CPB) onward
  - stop bit ends at E(10·CPB+1)
- o_TX_Done is high for exactly the one cycle beginning at E(10·CPB+1). o_TX_Active is high over E1..E(10·CPB+1) exclusive.
- Back-to-back frames: after the stop bit, CLEANUP then IDLE. The line stays high for 2 extra cycles, then the next start bit begins.
- Total frame period at steady state is 10·CPB+2 cycles.
- o_TX_Ready deasserts in the same cycle o_FIFO_Count reaches FIFO_DEPTH. It reasserts in the cycle after the next pop.

## Test plan
- Single byte, CPB=4: write 0xA5 at E0 -> serial 0 for E1–E4, then data 1,0,1,0,0,1,0,1 (4 cycles each), then stop 1 for E37–E40; o_TX_Done high only in cycle E41; Active high E1–E40.
- Default CPB=217: write 0x00 -> start bit measured exactly 217 cycles low, data 8·217 low, stop 217 high, Done once.
- Overflow, DEPTH=4, CPB=4: hold i_TX_DV for 6 consecutive cycles with bytes 0x10..0x15 -> 0x10 pops at E1; 0x11–0x14 fill FIFO (count=4, Ready=0 after E4); 0x15 dropped; serial output 0x10,0x11,0x12,0x13,0x14 in order, five Done pulses, frames spaced 10·4+2=42 cycles.
- Simultaneous push/pop, DEPTH=4, CPB=4: with count=2, write exactly on the IDLE pop edge -> count stays 2, both bytes transmitted in order.
- Reset mid-frame: assert i_Rst during data bit 3 of 0x3C -> o_TX_Serial=1 with no clock edge, count=0, Ready=1, no Done. After release, write 0x55 -> a clean full frame of 0x55 only.
- Pointer wrap: 10 bytes 0x01..0x0A written, each after the previous Done -> all 10 frames correct, count never exceeds 1.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular byte FIFO.
// The FIFO pops only while the line is idle; each frame is start, 8 data bits LSB first, stop.
module uart_tx_fifo #(
    parameter int CLOCKS_PER_BIT = 217,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic                          i_TX_DV,
    input  logic [7:0]                    i_TX_Byte,
    output logic                          o_TX_Ready,
    output logic                          o_TX_Serial,
    output logic                          o_TX_Active,
    output logic                          o_TX_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count
);

    localparam int CNT_W = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA_BITS = 3'd2,
        STOP_BIT  = 3'd3,
        CLEANUP   = 3'd4
    } state_t;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             serial_q, serial_d;
    logic             active_q, active_d;
    logic             done_q, done_d;

    logic             push;
    logic             pop;
    logic             bit_end;
    logic [2:0]       bit_nxt;

    assign o_TX_Ready   = (count_q != FIFO_FULL);
    assign o_TX_Serial  = serial_q;
    assign o_TX_Active  = active_q;
    assign o_TX_Done    = done_q;
    assign o_FIFO_Count = count_q;

    assign push    = i_TX_DV && o_TX_Ready;
    assign pop     = (state_q == IDLE) && (count_q != '0);
    assign bit_end = (cnt_q == CNT_MAX);
    assign bit_nxt = bit_q + 3'd1;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // A simultaneous push and pop leaves the occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        serial_d = serial_q;
        active_d = active_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                active_d = 1'b0;
                cnt_d    = '0;
                bit_d    = '0;
                if (pop) begin
                    shift_d  = mem_q[rd_ptr_q];
                    serial_d = 1'b0;
                    active_d = 1'b1;
                    state_d  = START_BIT;
                end
            end
            START_BIT: begin
                serial_d = 1'b0;
                if (bit_end) begin
                    cnt_d    = '0;
                    serial_d = shift_q[0];
                    bit_d    = '0;
                    state_d  = DATA_BITS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA_BITS: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q < 3'd7) begin
                        bit_d    = bit_nxt;
                        serial_d = shift_q[bit_nxt];
                    end else begin
                        serial_d = 1'b1;
                        state_d  = STOP_BIT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP_BIT: begin
                serial_d = 1'b1;
                if (bit_end) begin
                    cnt_d    = '0;
                    active_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = CLEANUP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLEANUP: begin
                serial_d = 1'b1;
                active_d = 1'b0;
                cnt_d    = '0;
                state_d  = IDLE;
            end
            default: begin
                serial_d = 1'b1;
                active_d = 1'b0;
                cnt_d    = '0;
                bit_d    = '0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    // Storage carries no reset; the pointers and count define which entries are live.
    always_ff @(posedge i_Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_TX_Byte;
        end
    end

endmodule
